// File: rtl/instr_fetch_if.sv
// RAM read channel shared by fetch-style clients and the RAM controller.
// Client drives the request; Server returns data and completion.
interface RAMReadChannel;
    logic [31:0] address;
    logic [1:0]  sig_read;
    logic [31:0] data;
    logic        is_ready;

    modport Client (output address, output sig_read, input data, input is_ready);
    modport Server (input address, input sig_read, output data, output is_ready);
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: one word read in flight, results queued with their PCs.
// Optional FETCH_FAULT_EN adds a sticky misaligned-PC fault that halts issuing.
module instr_fetch #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          reset,
    RAMReadChannel.Client ram,
    input  logic          redirect,
    input  logic [31:0]   redirect_pc,
    output logic          instr_valid,
    output logic [31:0]   instr,
    output logic [31:0]   instr_pc,
    input  logic          instr_ready
`ifdef FETCH_FAULT_EN
   ,output logic          fetch_fault
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT1, S_WAIT} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } fetch_entry_t;

    state_t             state_q;
    logic [1:0]         sig_read_q;
    logic [31:0]        address_q;
    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic               discard_q;
    logic               fault_q, fault_d;
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q, count_d;
    fetch_entry_t       mem_q [DEPTH];

    logic pop, push, room;

    // Next-state values shared by the FIFO and the request sequencer.
    always_comb begin
        pop        = (count_q != '0) && instr_ready;
        push       = (state_q == S_WAIT) && ram.is_ready && !discard_q && !redirect;
        count_d    = count_q;
        fetch_pc_d = fetch_pc_q;
        if (redirect) begin
            count_d    = '0;
            fetch_pc_d = redirect_pc;
        end else begin
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
            if (push) fetch_pc_d = fetch_pc_q + 32'd4;
        end
`ifdef FETCH_FAULT_EN
        fault_d = fault_q;
        if (redirect) fault_d = (redirect_pc[1:0] != 2'b00);
`else
        fault_d = 1'b0;
`endif
        room = (count_d < CNT_W'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            sig_read_q <= 2'd0;
            address_q  <= 32'd0;
            fetch_pc_q <= RESET_PC;
            discard_q  <= 1'b0;
`ifdef FETCH_FAULT_EN
            fault_q    <= (RESET_PC[1:0] != 2'b00);
`else
            fault_q    <= 1'b0;
`endif
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            fault_q    <= fault_d;
            if (redirect) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end

            sig_read_q <= 2'd0;
            unique case (state_q)
                S_IDLE: begin
                    if (!redirect && (count_q < CNT_W'(DEPTH)) && !fault_q) begin
                        state_q    <= S_ISSUE;
                        sig_read_q <= 2'd3;
                        address_q  <= fetch_pc_q;
                    end
                end
                S_ISSUE: begin
                    state_q <= S_WAIT1;
                    if (redirect) discard_q <= 1'b1;
                end
                S_WAIT1: begin
                    state_q <= S_WAIT;
                    if (redirect) discard_q <= 1'b1;
                end
                S_WAIT: begin
                    // A redirect landing on the completing cycle leaves nothing in flight to discard.
                    if (ram.is_ready) begin
                        discard_q <= 1'b0;
                        if (room && !fault_d) begin
                            state_q    <= S_ISSUE;
                            sig_read_q <= 2'd3;
                            address_q  <= fetch_pc_d;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else if (redirect) begin
                        discard_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Entry storage carries no reset; validity is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= '{pc: fetch_pc_q, word: ram.data};
    end

    assign ram.sig_read = sig_read_q;
    assign ram.address  = address_q;
    assign instr_valid  = (count_q != '0);
    assign instr        = mem_q[rd_ptr_q].word;
    assign instr_pc     = mem_q[rd_ptr_q].pc;
`ifdef FETCH_FAULT_EN
    assign fetch_fault  = fault_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: randomized-latency RAM model plus a PC-stream scoreboard.
module tb_instr_fetch;

    localparam logic [31:0] MASK = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b1;
`ifdef FETCH_FAULT_EN
    logic        fetch_fault;
`endif

    int errors = 0;
    int checks = 0;
    int issues = 0;
    int done_cnt = 0;
    int pops_total = 0;
    logic [31:0] popped_q[$];

    RAMReadChannel ram_if();

    instr_fetch #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .reset       (reset),
        .ram         (ram_if),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready)
`ifdef FETCH_FAULT_EN
       ,.fetch_fault (fetch_fault)
`endif
    );

    always #5 clk = ~clk;

    // RAM controller model: latches on a 0->nonzero edge, completes after a random delay.
    logic [1:0]  ram_prev;
    logic        ram_busy;
    logic [31:0] ram_addr;
    int          ram_lat;
    always @(posedge clk) begin
        if (reset) begin
            ram_prev        <= 2'd0;
            ram_busy        <= 1'b0;
            ram_if.is_ready <= 1'b1;
            ram_if.data     <= 32'd0;
        end else begin
            ram_prev <= ram_if.sig_read;
            if (ram_if.sig_read != 2'd0 && ram_prev == 2'd0) begin
                ram_busy        <= 1'b1;
                ram_if.is_ready <= 1'b0;
                ram_addr        <= ram_if.address;
                ram_lat         <= int'($urandom_range(3, 6));
            end else if (ram_busy) begin
                if (ram_lat == 0) begin
                    ram_busy        <= 1'b0;
                    ram_if.is_ready <= 1'b1;
                    ram_if.data     <= ram_addr ^ MASK;
                    done_cnt        <= done_cnt + 1;
                end else begin
                    ram_lat <= ram_lat - 1;
                end
            end
        end
    end

    // Scoreboard: popped entries must follow the expected PC stream, data = pc ^ MASK.
    logic [31:0] exp_pc = 32'd0;
    logic [1:0]  mon_prev_sr = 2'd0;
    always @(negedge clk) begin
        if (reset) begin
            exp_pc      = 32'd0;
            mon_prev_sr = 2'd0;
        end else begin
            if (ram_if.sig_read != 2'd0) begin
                issues++;
                checks++;
                if (ram_if.sig_read !== 2'd3 || mon_prev_sr != 2'd0) begin
                    errors++;
                    $display("FAIL sig_read_pulse: got %0d prev %0d, need 3 after 0", ram_if.sig_read, mon_prev_sr);
                end
            end
            if (redirect) begin
                exp_pc = redirect_pc;
            end else if (instr_valid && instr_ready) begin
                checks++;
                if (instr_pc !== exp_pc || instr !== (exp_pc ^ MASK)) begin
                    errors++;
                    $display("FAIL pop_entry: got pc %h data %h, need pc %h data %h", instr_pc, instr, exp_pc, exp_pc ^ MASK);
                end
                popped_q.push_back(instr_pc);
                pops_total++;
                exp_pc = exp_pc + 32'd4;
            end
            mon_prev_sr = ram_if.sig_read;
        end
    end

    task automatic do_reset(input logic rdy);
        reset       = 1'b1;
        redirect    = 1'b0;
        instr_ready = rdy;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        issues = 0;
        popped_q.delete();
    endtask

    task automatic wait_pops(input int n);
        int k = 0;
        while (popped_q.size() < n && k < 400) begin
            @(posedge clk); #1; k++;
        end
    endtask

    task automatic test_reset;
        logic [31:0] got;
        reset = 1'b1; redirect = 1'b0; instr_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b need 0", instr_valid); end
        checks++; if (ram_if.sig_read !== 2'd0) begin errors++; $display("FAIL reset_sig_read: got %0d need 0", ram_if.sig_read); end
        checks++; if (ram_if.address !== 32'd0) begin errors++; $display("FAIL reset_address: got %h need 0", ram_if.address); end
`ifdef FETCH_FAULT_EN
        checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b need 0", fetch_fault); end
`endif
        reset = 1'b0;
        popped_q.delete();
        @(negedge clk);
        checks++; if (ram_if.sig_read !== 2'd0) begin errors++; $display("FAIL first_cycle_idle: got %0d need 0", ram_if.sig_read); end
        @(negedge clk);
        checks++; if (ram_if.sig_read !== 2'd3 || ram_if.address !== 32'd0) begin
            errors++; $display("FAIL first_issue: got sr %0d addr %h need 3 / 0", ram_if.sig_read, ram_if.address);
        end
        wait_pops(4);
        for (int i = 0; i < 4; i++) begin
            got = (i < popped_q.size()) ? popped_q[i] : 32'hDEAD_BEEF;
            checks++;
            if (got !== 32'(i * 4)) begin errors++; $display("FAIL seq_pc[%0d]: got %h need %h", i, got, 32'(i * 4)); end
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] got;
        do_reset(1'b0);
        repeat (80) @(posedge clk);
        #1;
        checks++; if (issues != 4) begin errors++; $display("FAIL full_issue_count: got %0d need 4", issues); end
        checks++; if (ram_if.sig_read !== 2'd0) begin errors++; $display("FAIL full_idle: got %0d need 0", ram_if.sig_read); end
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL full_valid: got %b need 1", instr_valid); end
        instr_ready = 1'b1;
        wait_pops(6);
        got = (popped_q.size() > 4) ? popped_q[4] : 32'hDEAD_BEEF;
        checks++; if (got !== 32'd16) begin errors++; $display("FAIL resume_pc: got %h need 00000010", got); end
    endtask

    task automatic test_redirect_wait;
        int k = 0;
        logic [31:0] got;
        do_reset(1'b1);
        while (!(ram_if.sig_read == 2'd3 && ram_if.address == 32'd8) && k < 200) begin
            @(negedge clk); k++;
        end
        checks++; if (k >= 200) begin errors++; $display("FAIL wait_issue8: got timeout need issue of pc 8"); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        redirect = 1'b1; redirect_pc = 32'h100;
        popped_q.delete();
        @(posedge clk); #1;
        redirect = 1'b0;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL redirect_flush: got %b need 0", instr_valid); end
        wait_pops(1);
        got = (popped_q.size() > 0) ? popped_q[0] : 32'hDEAD_BEEF;
        checks++; if (got !== 32'h100) begin errors++; $display("FAIL redirect_target: got %h need 00000100", got); end
    endtask

    task automatic test_redirect_completion;
        int k = 0;
        int d0;
        logic [31:0] got;
        do_reset(1'b0);
        d0 = done_cnt;
        while (done_cnt < d0 + 3 && k < 200) begin
            @(posedge clk); #1; k++;
        end
        checks++; if (instr_valid !== 1'b1 || ram_if.is_ready !== 1'b1) begin
            errors++; $display("FAIL completion_setup: got valid %b ready %b need 1/1", instr_valid, ram_if.is_ready);
        end
        redirect = 1'b1; redirect_pc = 32'h300; instr_ready = 1'b1;
        popped_q.delete();
        @(posedge clk); #1;
        redirect = 1'b0;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL completion_flush: got %b need 0", instr_valid); end
        wait_pops(1);
        got = (popped_q.size() > 0) ? popped_q[0] : 32'hDEAD_BEEF;
        checks++; if (got !== 32'h300) begin errors++; $display("FAIL completion_target: got %h need 00000300", got); end
    endtask

    task automatic test_wrap;
        logic [31:0] g1, g2;
        instr_ready = 1'b1;
        @(posedge clk); #1;
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        popped_q.delete();
        @(posedge clk); #1;
        redirect = 1'b0;
        wait_pops(3);
        g1 = (popped_q.size() > 1) ? popped_q[1] : 32'hDEAD_BEEF;
        g2 = (popped_q.size() > 2) ? popped_q[2] : 32'hDEAD_BEEF;
        checks++; if (g1 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_top: got %h need fffffffc", g1); end
        checks++; if (g2 !== 32'h0000_0000) begin errors++; $display("FAIL wrap_zero: got %h need 00000000", g2); end
    endtask

    task automatic test_random;
        int p0 = pops_total;
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #1;
            instr_ready = ($urandom_range(0, 3) != 0);
            redirect    = ($urandom_range(0, 24) == 0);
`ifdef FETCH_FAULT_EN
            redirect_pc = $urandom() & 32'hFFFF_FFFC;
`else
            redirect_pc = ($urandom_range(0, 3) == 0) ? $urandom() : ($urandom() & 32'hFFFF_FFFC);
`endif
        end
        @(posedge clk); #1;
        redirect = 1'b0; instr_ready = 1'b1;
        checks++; if (pops_total - p0 < 50) begin errors++; $display("FAIL random_progress: got %0d pops need >= 50", pops_total - p0); end
    endtask

`ifdef FETCH_FAULT_EN
    task automatic test_fault;
        logic [31:0] got;
        do_reset(1'b1);
        repeat (12) @(posedge clk);
        #1;
        redirect = 1'b1; redirect_pc = 32'h102;
        @(posedge clk); #1;
        redirect = 1'b0;
        issues = 0;
        checks++; if (fetch_fault !== 1'b1) begin errors++; $display("FAIL fault_set: got %b need 1", fetch_fault); end
        repeat (40) @(posedge clk);
        #1;
        checks++; if (issues != 0) begin errors++; $display("FAIL fault_halt: got %0d issues need 0", issues); end
        checks++; if (fetch_fault !== 1'b1) begin errors++; $display("FAIL fault_sticky: got %b need 1", fetch_fault); end
        redirect = 1'b1; redirect_pc = 32'h200;
        popped_q.delete();
        @(posedge clk); #1;
        redirect = 1'b0;
        checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL fault_clear: got %b need 0", fetch_fault); end
        wait_pops(1);
        got = (popped_q.size() > 0) ? popped_q[0] : 32'hDEAD_BEEF;
        checks++; if (got !== 32'h200) begin errors++; $display("FAIL fault_resume: got %h need 00000200", got); end
    endtask
`endif

    initial begin
        test_reset();
        test_backpressure();
        test_redirect_wait();
        test_redirect_completion();
        test_wrap();
        test_random();
`ifdef FETCH_FAULT_EN
        test_fault();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
